// File: rtl/decode_pipe_pkg.sv
// Shared decode definitions: RV32 opcodes, ALU operation codes, operand/write-back
// select encodings and the registered control bundle.
package decode_pipe_pkg;

  localparam int unsigned ALU_OP_BITS = 5;

  // Codes 0-9 are fixed by the earlier combinational control unit.
  typedef enum logic [ALU_OP_BITS-1:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'b00,
    OP1_PC   = 2'b01,
    OP1_ZERO = 2'b10
  } op1_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  localparam logic [6:0] F7_MEXT = 7'h01;

  typedef struct packed {
    alu_op_e  alu_op;
    op1_sel_e op1_sel;
    logic     op2_sel;
    wb_sel_e  mem_to_reg;
    logic     br_unsign;
    logic     branch;
    logic     jump;
    logic     mem_rden;
    logic     mem_wren;
    logic     rd_wren;
    logic     ctrl;
    logic     insn_vld;
    logic     multicycle;
    logic     md_div;
  } ctrl_t;

  // Register-register and immediate ALU ops share the funct3 mapping.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    unique case (funct3)
      3'b000:  alu_from_funct3 = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_from_funct3 = ALU_SLL;
      3'b010:  alu_from_funct3 = ALU_SLT;
      3'b011:  alu_from_funct3 = ALU_SLTU;
      3'b100:  alu_from_funct3 = ALU_XOR;
      3'b101:  alu_from_funct3 = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_from_funct3 = ALU_OR;
      default: alu_from_funct3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_pipe_decode.sv
// Purely combinational RV32I(+M) decoder: instruction word to control bundle.
// Illegal encodings produce an all-zero bundle, so every strobe is inactive.
module rv_decode
  import decode_pipe_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0] instr,
  output ctrl_t       bundle
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  ctrl_t      d;
  logic       legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    d     = '0;
    legal = 1'b0;
    unique case (opcode)
      OPC_LUI: begin
        legal     = 1'b1;
        d.op1_sel = OP1_ZERO;
        d.op2_sel = 1'b1;
        d.rd_wren = 1'b1;
      end
      OPC_AUIPC: begin
        legal     = 1'b1;
        d.op1_sel = OP1_PC;
        d.op2_sel = 1'b1;
        d.rd_wren = 1'b1;
      end
      OPC_JAL: begin
        legal        = 1'b1;
        d.op1_sel    = OP1_PC;
        d.op2_sel    = 1'b1;
        d.mem_to_reg = WB_PC4;
        d.jump       = 1'b1;
        d.ctrl       = 1'b1;
        d.rd_wren    = 1'b1;
      end
      OPC_JALR: begin
        legal        = (funct3 == 3'b000);
        d.op1_sel    = OP1_RS1;
        d.op2_sel    = 1'b1;
        d.mem_to_reg = WB_PC4;
        d.jump       = 1'b1;
        d.ctrl       = 1'b1;
        d.rd_wren    = 1'b1;
      end
      OPC_BRANCH: begin
        legal       = (funct3[2:1] != 2'b01);
        d.op1_sel   = OP1_PC;
        d.op2_sel   = 1'b1;
        d.branch    = 1'b1;
        d.ctrl      = 1'b1;
        d.br_unsign = (funct3[2:1] == 2'b11);
      end
      OPC_LOAD: begin
        legal        = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);
        d.op2_sel    = 1'b1;
        d.mem_to_reg = WB_MEM;
        d.mem_rden   = 1'b1;
        d.rd_wren    = 1'b1;
      end
      OPC_STORE: begin
        legal      = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
        d.op2_sel  = 1'b1;
        d.mem_wren = 1'b1;
      end
      OPC_IMM: begin
        d.op2_sel = 1'b1;
        d.rd_wren = 1'b1;
        // Only shifts carry funct7; SUB has no immediate form.
        unique case (funct3)
          3'b001: begin
            legal    = (funct7 == F7_BASE);
            d.alu_op = ALU_SLL;
          end
          3'b101: begin
            legal    = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            d.alu_op = alu_from_funct3(funct3, funct7 == F7_ALT);
          end
          default: begin
            legal    = 1'b1;
            d.alu_op = alu_from_funct3(funct3, 1'b0);
          end
        endcase
      end
      OPC_REG: begin
        d.rd_wren = 1'b1;
        unique case (funct7)
          F7_BASE: begin
            legal    = 1'b1;
            d.alu_op = alu_from_funct3(funct3, 1'b0);
          end
          F7_ALT: begin
            legal    = (funct3 == 3'b000) || (funct3 == 3'b101);
            d.alu_op = alu_from_funct3(funct3, 1'b1);
          end
          F7_MEXT: begin
            legal        = ENABLE_M;
            d.alu_op     = alu_op_e'(5'd10 + {2'b00, funct3});
            d.multicycle = 1'b1;
            d.md_div     = funct3[2];
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_FENCE:  legal = (funct3 == 3'b000);
      OPC_SYSTEM: legal = (instr == 32'h0000_0073) || (instr == 32'h0010_0073);
      default:    legal = 1'b0;
    endcase

    if (legal) begin
      bundle          = d;
      bundle.insn_vld = 1'b1;
    end else begin
      bundle = '0;
    end
  end

endmodule

// File: rtl/decode_pipe.sv
// Registered decode stage: rv_decode feeding a two-entry skid buffer with
// valid/ready on both sides, redirect flush and divider issue throttling.
module decode_pipe
  import decode_pipe_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ALU_OP_W   = 5,
  parameter bit          ENABLE_M   = 1'b1,
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [31:0]         i_instr,
  input  logic [XLEN-1:0]     i_pc,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [31:0]         o_instr,
  output logic [XLEN-1:0]     o_pc,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic [1:0]          o_op1_sel,
  output logic                o_op2_sel,
  output logic [1:0]          o_mem_to_reg,
  output logic                o_br_unsign,
  output logic                o_branch,
  output logic                o_jump,
  output logic                o_mem_rden,
  output logic                o_mem_wren,
  output logic                o_rd_wren,
  output logic                o_ctrl,
  output logic                o_insn_vld,
  output logic                o_multicycle
);

  localparam int unsigned CNT_W = $clog2(MD_LATENCY + 1);

  ctrl_t            dec;
  ctrl_t            main_ctrl;
  ctrl_t            skid_ctrl;
  logic [31:0]      main_instr;
  logic [31:0]      skid_instr;
  logic [XLEN-1:0]  main_pc;
  logic [XLEN-1:0]  skid_pc;
  logic             main_valid;
  logic             skid_valid;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  rv_decode #(
    .ENABLE_M(ENABLE_M)
  ) u_decode (
    .instr  (i_instr),
    .bundle (dec)
  );

  // A flushed cycle never accepts, even while o_ready is high.
  assign accept  = i_valid & o_ready & ~i_flush;
  assign o_ready = ~skid_valid & (cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      main_instr <= '0;
      skid_instr <= '0;
      main_pc    <= '0;
      skid_pc    <= '0;
    end else if (i_flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_valid && !i_ready) begin
      if (accept) begin
        skid_valid <= 1'b1;
        skid_ctrl  <= dec;
        skid_instr <= i_instr;
        skid_pc    <= i_pc;
      end
    end else if (skid_valid) begin
      // o_ready is low whenever skid is full, so nothing new arrives here.
      main_valid <= 1'b1;
      skid_valid <= 1'b0;
      main_ctrl  <= skid_ctrl;
      main_instr <= skid_instr;
      main_pc    <= skid_pc;
    end else begin
      main_valid <= accept;
      if (accept) begin
        main_ctrl  <= dec;
        main_instr <= i_instr;
        main_pc    <= i_pc;
      end
    end
  end

  // The divider stays busy across a flush, so the counter ignores it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (accept && dec.md_div) begin
      cnt <= CNT_W'(MD_LATENCY);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign o_valid      = main_valid;
  assign o_instr      = main_instr;
  assign o_pc         = main_pc;
  assign o_alu_op     = ALU_OP_W'(main_ctrl.alu_op);
  assign o_op1_sel    = main_ctrl.op1_sel;
  assign o_op2_sel    = main_ctrl.op2_sel;
  assign o_mem_to_reg = main_ctrl.mem_to_reg;
  assign o_br_unsign  = main_ctrl.br_unsign;
  assign o_branch     = main_ctrl.branch;
  assign o_jump       = main_ctrl.jump;
  assign o_mem_rden   = main_ctrl.mem_rden;
  assign o_mem_wren   = main_ctrl.mem_wren;
  assign o_rd_wren    = main_ctrl.rd_wren;
  assign o_ctrl       = main_ctrl.ctrl;
  assign o_insn_vld   = main_ctrl.insn_vld;
  assign o_multicycle = main_ctrl.multicycle;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: table of instructions with hand-derived control bundles
// streamed through a scoreboard, plus directed skid, throttle, flush and no-M cases.
module tb_decode_pipe;

  typedef struct packed {
    logic [4:0] alu;
    logic [1:0] op1;
    logic       op2;
    logic [1:0] m2r;
    logic [8:0] f;  // bru br jmp rden wren rdw ctrl vld mc
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    exp_t        e;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_ready = 1'b0;
  logic        rdy_set = 1'b0;
  logic        rand_rdy = 1'b0;
  exp_t        cur_e = '0;
  logic [31:0] pc_ctr = 32'h1000;

  logic        o_ready, o_valid, o_op2_sel, o_br_unsign, o_branch, o_jump;
  logic        o_mem_rden, o_mem_wren, o_rd_wren, o_ctrl, o_insn_vld, o_multicycle;
  logic [31:0] o_instr, o_pc;
  logic [4:0]  o_alu_op;
  logic [1:0]  o_op1_sel, o_mem_to_reg;

  logic        v2 = 1'b0;
  logic [31:0] instr2 = '0;
  logic        ready2 = 1'b1;
  logic        o_ready2, o_valid2, o_op2_sel2, o_br_unsign2, o_branch2, o_jump2;
  logic        o_mem_rden2, o_mem_wren2, o_rd_wren2, o_ctrl2, o_insn_vld2, o_multicycle2;
  logic [31:0] o_instr2, o_pc2;
  logic [4:0]  o_alu_op2;
  logic [1:0]  o_op1_sel2, o_mem_to_reg2;

  sb_t         sbq[$];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  vec_t        vec[16];

  always #5 clk = ~clk;

  decode_pipe #(.XLEN(32), .ALU_OP_W(5), .ENABLE_M(1'b1), .MD_LATENCY(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(o_ready),
    .i_instr(in_instr), .i_pc(in_pc), .o_valid(o_valid), .i_ready(out_ready),
    .o_instr(o_instr), .o_pc(o_pc), .o_alu_op(o_alu_op), .o_op1_sel(o_op1_sel),
    .o_op2_sel(o_op2_sel), .o_mem_to_reg(o_mem_to_reg), .o_br_unsign(o_br_unsign),
    .o_branch(o_branch), .o_jump(o_jump), .o_mem_rden(o_mem_rden), .o_mem_wren(o_mem_wren),
    .o_rd_wren(o_rd_wren), .o_ctrl(o_ctrl), .o_insn_vld(o_insn_vld), .o_multicycle(o_multicycle)
  );

  decode_pipe #(.XLEN(32), .ALU_OP_W(5), .ENABLE_M(1'b0), .MD_LATENCY(4)) dut_nom (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(1'b0), .i_valid(v2), .o_ready(o_ready2),
    .i_instr(instr2), .i_pc(32'h2000), .o_valid(o_valid2), .i_ready(ready2),
    .o_instr(o_instr2), .o_pc(o_pc2), .o_alu_op(o_alu_op2), .o_op1_sel(o_op1_sel2),
    .o_op2_sel(o_op2_sel2), .o_mem_to_reg(o_mem_to_reg2), .o_br_unsign(o_br_unsign2),
    .o_branch(o_branch2), .o_jump(o_jump2), .o_mem_rden(o_mem_rden2), .o_mem_wren(o_mem_wren2),
    .o_rd_wren(o_rd_wren2), .o_ctrl(o_ctrl2), .o_insn_vld(o_insn_vld2), .o_multicycle(o_multicycle2)
  );

  function automatic exp_t mk(input logic [4:0] alu, input logic [1:0] op1, input logic op2,
                              input logic [1:0] m2r, input logic [8:0] f);
    mk = {alu, op1, op2, m2r, f};
  endfunction

  function automatic exp_t bundle1();
    bundle1 = {o_alu_op, o_op1_sel, o_op2_sel, o_mem_to_reg, o_br_unsign, o_branch, o_jump,
               o_mem_rden, o_mem_wren, o_rd_wren, o_ctrl, o_insn_vld, o_multicycle};
  endfunction

  function automatic exp_t bundle2();
    bundle2 = {o_alu_op2, o_op1_sel2, o_op2_sel2, o_mem_to_reg2, o_br_unsign2, o_branch2, o_jump2,
               o_mem_rden2, o_mem_wren2, o_rd_wren2, o_ctrl2, o_insn_vld2, o_multicycle2};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    sb_t s;
    #4;
    if (rst_n && !flush) begin
      if (o_valid && out_ready) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got instr %h, required no output", o_instr);
        end else begin
          s = sbq.pop_front();
          check("bundle", 64'(bundle1()), 64'(s.e));
          check("instr_pc", {o_instr, o_pc}, {s.instr, s.pc});
        end
      end
      if (in_valid && o_ready) sbq.push_back('{in_instr, in_pc, cur_e});
    end
  end

  always @(negedge clk) begin
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_set;
  end

  task automatic send(input logic [31:0] ins, input exp_t e);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc_ctr;
    cur_e    = e;
    n_chk++;
    for (int n = 0; n < 40; n++) begin
      #4;
      if (o_ready) begin
        pc_ctr += 32'd4;
        return;
      end
      @(negedge clk);
    end
    n_fail++;
    $display("FAIL send_timeout: got no accept of %h, required accept within 40 cycles", ins);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && sbq.size() != 0; n++) @(negedge clk);
    check("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  task automatic nom(input string name, input logic [31:0] ins, input exp_t e);
    @(negedge clk);
    v2     = 1'b1;
    instr2 = ins;
    @(posedge clk);
    #1;
    v2 = 1'b0;
    check({name, "_valid"}, 64'(o_valid2), 64'd1);
    check({name, "_bundle"}, 64'(bundle2()), 64'(e));
    check({name, "_ready"}, 64'(o_ready2), 64'd1);
  endtask

  initial begin
    exp_t e_add, e_div, e_ill;
    int unsigned lows;
    e_add = mk(5'd0, 2'b00, 1'b0, 2'b00, 9'b000001010);
    e_div = mk(5'd14, 2'b00, 1'b0, 2'b00, 9'b000001011);
    e_ill = '0;
    vec[0]  = '{32'h002081B3, e_add};
    vec[1]  = '{32'h123452B7, mk(5'd0, 2'b10, 1'b1, 2'b00, 9'b000001010)};  // LUI
    vec[2]  = '{32'h00001317, mk(5'd0, 2'b01, 1'b1, 2'b00, 9'b000001010)};  // AUIPC
    vec[3]  = '{32'h008000EF, mk(5'd0, 2'b01, 1'b1, 2'b10, 9'b001001110)};  // JAL
    vec[4]  = '{32'h000100E7, mk(5'd0, 2'b00, 1'b1, 2'b10, 9'b001001110)};  // JALR
    vec[5]  = '{32'h0020E863, mk(5'd0, 2'b01, 1'b1, 2'b00, 9'b110000110)};  // BLTU
    vec[6]  = '{32'h0040A203, mk(5'd0, 2'b00, 1'b1, 2'b01, 9'b000101010)};  // LW
    vec[7]  = '{32'h0020A423, mk(5'd0, 2'b00, 1'b1, 2'b00, 9'b000010010)};  // SW
    vec[8]  = '{32'h402081B3, mk(5'd1, 2'b00, 1'b0, 2'b00, 9'b000001010)};  // SUB
    vec[9]  = '{32'h4020D193, mk(5'd7, 2'b00, 1'b1, 2'b00, 9'b000001010)};  // SRAI
    vec[10] = '{32'h022081B3, mk(5'd10, 2'b00, 1'b0, 2'b00, 9'b000001011)}; // MUL
    vec[11] = '{32'h0000007F, e_ill};                                       // bad opcode
    vec[12] = '{32'h0020A063, e_ill};                                       // branch f3=010
    vec[13] = '{32'hFFF0C193, mk(5'd5, 2'b00, 1'b1, 2'b00, 9'b000001010)};  // XORI
    vec[14] = '{32'h0020B1B3, mk(5'd4, 2'b00, 1'b0, 2'b00, 9'b000001010)};  // SLTU
    vec[15] = '{32'h0020D863, mk(5'd0, 2'b01, 1'b1, 2'b00, 9'b010000110)};  // BGE

    repeat (3) @(negedge clk);
    check("reset_valid", 64'(o_valid), 64'd0);
    check("reset_regs", {o_instr, o_pc}, 64'd0);
    check("reset_bundle", 64'(bundle1()), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_ready", 64'(o_ready), 64'd1);

    rdy_set = 1'b1;
    send(vec[0].instr, vec[0].e);
    @(posedge clk);
    #1;
    check("latency_valid", 64'(o_valid), 64'd1);
    check("latency_instr", 64'(o_instr), 64'h002081B3);
    idle();

    foreach (vec[i]) send(vec[i].instr, vec[i].e);
    idle();
    drain();

    rand_rdy = 1'b1;
    for (int r = 0; r < 3; r++)
      foreach (vec[i]) begin
        if ($urandom_range(0, 3) == 0) idle();
        send(vec[i].instr, vec[i].e);
      end
    idle();
    rand_rdy = 1'b0;
    drain();

    // Skid fill with downstream stalled: third instruction must wait.
    rdy_set = 1'b0;
    send(vec[1].instr, vec[1].e);
    send(vec[2].instr, vec[2].e);
    @(negedge clk);
    in_instr = vec[3].instr;
    cur_e    = vec[3].e;
    #4;
    check("skid_ready_low", 64'(o_ready), 64'd0);
    check("skid_hold_instr", 64'(o_instr), 64'(vec[1].instr));
    @(negedge clk);
    #4;
    check("skid_ready_low2", 64'(o_ready), 64'd0);
    rdy_set = 1'b1;
    send(vec[3].instr, vec[3].e);
    idle();
    drain();

    send(32'h0220C1B3, e_div);
    idle();
    #4;
    lows = 0;
    while (!o_ready && lows < 20) begin
      lows++;
      @(negedge clk);
      #4;
    end
    check("div_throttle_cycles", 64'(lows), 64'd4);
    drain();

    // Flush right after a DIV: entry dies, throttle keeps running.
    send(32'h0220C1B3, e_div);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    sbq.delete();
    #4;
    check("flush_keeps_cnt", 64'(o_ready), 64'd0);
    check("flush_div_gone", 64'(o_valid), 64'd0);
    for (int n = 0; n < 20 && !o_ready; n++) @(negedge clk);

    rdy_set = 1'b0;
    send(vec[4].instr, vec[4].e);
    send(vec[5].instr, vec[5].e);
    @(negedge clk);
    in_instr = vec[6].instr;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    check("flush_full_valid", 64'(o_valid), 64'd0);
    check("flush_full_ready", 64'(o_ready), 64'd1);
    @(negedge clk);
    in_instr = vec[7].instr;
    #4;
    check("flush_empty_ready", 64'(o_ready), 64'd1);
    @(posedge clk);
    #1;
    check("flush_drop_valid", 64'(o_valid), 64'd0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    sbq.delete();
    rdy_set = 1'b1;
    send(vec[13].instr, vec[13].e);
    idle();
    drain();

    nom("nom_div", 32'h0220C1B3, e_ill);
    nom("nom_mul", 32'h022081B3, e_ill);
    nom("nom_bad_opcode", 32'h0000007F, e_ill);
    nom("nom_add", 32'h002081B3, e_add);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/decode_pipe.md
# decode_pipe

Parametrised, registered successor to the combinational control unit. It decodes RV32I instructions, plus RV32M when enabled, into the full control bundle, and holds the result in a two-entry skid buffer with valid/ready handshakes on both sides. It sits between the IF/ID and ID/EX boundaries of the pipeline. It adds illegal-instruction detection, flush, correct operand/write-back selects for LUI/AUIPC/JAL/JALR, and issue throttling for multi-cycle M-extension ops.

## Interface
- XLEN, 32, PC/data width
- ALU_OP_W, 5, width of ALU opcode field
- ENABLE_M, 1, decode RV32M; when 0, RV32M encodings are illegal
- MD_LATENCY, 4, cycles the input is blocked after accepting DIV/DIVU/REM/REMU (≥1)

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  kill all held entries (redirect)
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  block can accept
- i_instr  in  32  instruction word
- i_pc  in  XLEN  instruction PC
- o_valid  out  1  decoded bundle valid
- i_ready  in  1  downstream can accept
- o_instr  out  32  instruction passthrough
- o_pc  out  XLEN  PC passthrough
- o_alu_op  out  ALU_OP_W  ALU operation (package enum)
- o_op1_sel  out  2  00 rs1, 01 pc, 10 zero
- o_op2_sel  out  1  0 rs2, 1 imm
- o_mem_to_reg  out  2  00 alu, 01 load data, 10 pc+4
- o_br_unsign  out  1  unsigned compare (BLTU/BGEU only)
- o_branch, o_jump, o_mem_rden, o_mem_wren, o_rd_wren  out  1 each  control strobes
- o_ctrl  out  1  control-flow instruction (B/JAL/JALR)
- o_insn_vld  out  1  instruction legal
- o_multicycle  out  1  M-extension op

## Operation
- Decode is combinational on i_instr. Entries are registered only on an input handshake (i_valid & o_ready).
- Storage: a main register (drives outputs) and a skid register, each with a valid bit.
- Illegal instruction: unknown opcode, bad funct3/funct7, or M-op with ENABLE_M=0. It is forwarded with o_insn_vld=0 and rd_wren=mem_wren=mem_rden=branch=jump=0.
- Per-opcode selects:
  - LUI: op1=zero, op2=imm, add.
  - AUIPC: op1=pc, op2=imm, add.
  - JAL: op1=pc, op2=imm, mem_to_reg=10.
  - JALR: op1=rs1, op2=imm, mem_to_reg=10.
  - Loads: mem_to_reg=01.
  - B-type: op1=pc, op2=imm, add, branch=1.
- ALU op encoding: add 0, sub 1, sll 2, slt 3, sltu 4, xor 5, srl 6, sra 7, or 8, and 9, mul 10, mulh 11, mulhsu 12, mulhu 13, div 14, divu 15, rem 16, remu 17.
- Throttle counter: loaded with MD_LATENCY when a DIV/DIVU/REM/REMU is accepted. It decrements each cycle to 0.
- o_ready = ~skid_valid & (cnt==0).

## Timing
- Reset: o_valid=0, both valid bits 0, cnt=0, all registered outputs 0. o_ready=1 from the first cycle after deassertion.
- Latency: 1 cycle. An instruction accepted at edge N is on the outputs with o_valid=1 after edge N.
- Main empty, or main full with i_ready=1: the accepted entry goes to main. Simultaneous in/out gives full throughput.
- Main full, i_ready=0, accept: entry goes to skid. o_ready drops the next cycle.
- Output handshake with skid full: main ← skid, skid cleared. o_ready returns the following cycle if cnt==0.
- Outputs hold stable while o_valid & ~i_ready.
- i_flush (sampled at edge): both valid bits are cleared. Any input presented that cycle is dropped, even if o_ready=1. cnt is NOT cleared, because the divider is still busy. Flush wins over all handshakes.
- Reset mid-operation clears all state immediately, asynchronously.
- cnt counts down regardless of downstream stall. Back-to-back DIVs are separated by ≥MD_LATENCY+1 cycles at the input.

## Structure
- Shared package: opcode constants, the alu_op_e enum (ALU_OP_W wide), and the op1_sel/mem_to_reg encodings. The package must stay backward-compatible with the existing control-unit opcodes 0–9.
- Sub-module: rv_decode, purely combinational (instr → bundle struct). decode_pipe instantiates it and holds the skid buffer, the throttle counter and flush.
- The bundle struct is defined in the package and stored whole in both entries.

## Test plan
- Reset then ADD x3,x1,x2 (0x002081B3) with i_ready=1 → next cycle o_valid=1, alu_op=0, op1_sel=00, op2_sel=0, rd_wren=1, o_insn_vld=1.
- Stream LUI, AUIPC, JAL, JALR, BLTU:
  - LUI: op1_sel=10.
  - AUIPC: op1_sel=01.
  - JAL and JALR: mem_to_reg=10; JALR op1_sel=00.
  - BLTU: br_unsign=1, o_ctrl=1.
- Hold i_ready=0 and push 3 instrs → 2 accepted, o_ready=0 after the second. Raise i_ready → outputs in order, no loss or duplication.
- DIV (0x0220C1B3) with MD_LATENCY=4 → o_ready low for exactly 4 cycles. With ENABLE_M=0: accepted, o_insn_vld=0, rd_wren=0, no throttle.
- Assert i_flush with both entries full and i_valid=1 → next cycle o_valid=0, o_ready=1, and the flushed-cycle input never appears at the output.
- Opcode 0x7F, or ADD with funct7=0x01 when ENABLE_M=0 → o_insn_vld=0, all write/branch strobes 0.
